// File: rtl/anim_pkg.sv
// Shared types and constants for the 7-segment animation sequencer.
package anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    localparam int         FRAME_W   = 5;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/anim_sequencer_if.sv
// Control, decoder and display signals of the animation sequencer.
interface anim_sequencer_if #(
    parameter int NDIG = 9
) ();

    logic                          start;
    logic                          stop;
    logic                          pause;
    logic [1:0]                    mode;
    logic                          dir;
    logic [1:0]                    speed;
    logic [7*NDIG-1:0]             seg_bus;
    logic [anim_pkg::FRAME_W-1:0]  frame;
    logic [6:0]                    seg;
    logic [NDIG-1:0]               an;
    logic                          busy;
    logic                          done;
    logic                          frame_tick;

    modport master (
        output start, stop, pause, mode, dir, speed, seg_bus,
        input  frame, seg, an, busy, done, frame_tick
    );

    modport slave (
        input  start, stop, pause, mode, dir, speed, seg_bus,
        output frame, seg, an, busy, done, frame_tick
    );

endinterface

// File: rtl/led_scan.sv
// Time-multiplexes NDIG active-low decoder patterns onto one segment bus.
module led_scan
    import anim_pkg::*;
#(
    parameter int NDIG     = 9,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blank,
    input  logic [7*NDIG-1:0] seg_bus,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [SW-1:0] slot;
    logic [DW-1:0] digit;

    // Free-running slot counter; each wrap moves the scan to the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot  <= '0;
            digit <= '0;
        end else if (slot == SW'(SCAN_DIV - 1)) begin
            slot  <= '0;
            digit <= (digit == DW'(NDIG - 1)) ? '0 : digit + DW'(1);
        end else begin
            slot <= slot + SW'(1);
        end
    end

    // Register the selected pattern and its enable; blanking only gates outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else if (blank) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_bus[7*digit +: 7];
            an  <= ~(NDIG'(1) << digit);
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Frame sequencer (loop / one-shot / ping-pong) plus shared display scanner.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int NDIG      = 9,
    parameter int FRAME_DIV = 50000,
    parameter int SCAN_DIV  = 1000,
    parameter int LAST      = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    anim_sequencer_if.slave  bus
);

    // Wide enough for the slowest period (speed 3 = 8x base).
    localparam int                   PW    = $clog2(FRAME_DIV * 8);
    localparam logic [FRAME_W-1:0]   LASTF = FRAME_W'(LAST);

    state_t               state;
    logic [1:0]           mode_q;
    logic [1:0]           speed_q;
    logic                 down;
    logic [PW-1:0]        presc;
    logic [PW-1:0]        term;
    logic [FRAME_W-1:0]   frame_q;
    logic [FRAME_W-1:0]   nxt_frame;
    logic                 nxt_down;
    logic                 at_end;
    logic                 tick_q;
    logic                 done_q;

    assign term   = PW'((FRAME_DIV << speed_q) - 1);
    assign at_end = down ? (frame_q == '0) : (frame_q == LASTF);

    // Next frame on a tick: ping-pong bounces off the endpoint, others wrap.
    always_comb begin
        nxt_frame = frame_q;
        nxt_down  = down;
        if (mode_q == MODE_PINGPONG && at_end) begin
            nxt_down  = ~down;
            nxt_frame = down ? frame_q + FRAME_W'(1) : frame_q - FRAME_W'(1);
        end else if (at_end) begin
            nxt_frame = down ? LASTF : '0;
        end else begin
            nxt_frame = down ? frame_q - FRAME_W'(1) : frame_q + FRAME_W'(1);
        end
    end

    // Control FSM, prescaler and frame counter; stop > start > pause > tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_LOOP;
            speed_q <= '0;
            down    <= 1'b0;
            presc   <= '0;
            frame_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.stop) begin
                state   <= ST_IDLE;
                frame_q <= '0;
                presc   <= '0;
            end else if (bus.start) begin
                mode_q  <= bus.mode;
                speed_q <= bus.speed;
                down    <= bus.dir;
                frame_q <= bus.dir ? LASTF : '0;
                presc   <= '0;
                state   <= ST_RUN;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (bus.pause) begin
                            state <= ST_PAUSE;
                        end else if (presc == term) begin
                            presc <= '0;
                            if (mode_q == MODE_ONESHOT && at_end) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
                                frame_q <= nxt_frame;
                                down    <= nxt_down;
                                tick_q  <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (!bus.pause) state <= ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.frame      = frame_q;
    assign bus.busy       = (state == ST_RUN) || (state == ST_PAUSE);
    assign bus.done       = done_q;
    assign bus.frame_tick = tick_q;

    led_scan #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .blank   (state == ST_IDLE),
        .seg_bus (bus.seg_bus),
        .seg     (bus.seg),
        .an      (bus.an)
    );

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed + random bench for anim_sequencer against a cycle-level reference model.
module tb_anim_sequencer;

    localparam int NDIG      = 9;
    localparam int FRAME_DIV = 4;
    localparam int SCAN_DIV  = 2;
    localparam int LAST      = 31;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    anim_sequencer_if #(.NDIG(NDIG)) bus ();

    anim_sequencer #(
        .NDIG      (NDIG),
        .FRAME_DIV (FRAME_DIV),
        .SCAN_DIV  (SCAN_DIV),
        .LAST      (LAST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int              m_st, m_frame, m_el, m_period, m_step, m_mode, m_t;
    logic [6:0]      e_seg;
    logic [NDIG-1:0] e_an;
    logic            e_tick, e_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_frame = 0; m_el = 0; m_period = FRAME_DIV;
        m_step = 1; m_mode = 0; m_t = 0;
        e_seg = 7'h7F; e_an = '1; e_tick = 1'b0; e_done = 1'b0;
    endtask

    // One frame advance following the mode's rules on the frame range 0..LAST.
    task automatic model_advance();
        int nf;
        nf = m_frame + m_step;
        if (m_mode == 1) begin
            if (nf < 0 || nf > LAST) begin m_st = M_DONE; e_done = 1'b1; end
            else begin m_frame = nf; e_tick = 1'b1; end
        end else if (m_mode == 2) begin
            if (nf < 0 || nf > LAST) m_step = -m_step;
            m_frame = m_frame + m_step;
            e_tick = 1'b1;
        end else begin
            m_frame = (nf + LAST + 1) % (LAST + 1);
            e_tick = 1'b1;
        end
    endtask

    task automatic model_edge(input logic s, input logic sp, input logic ps);
        int dg;
        logic [7*NDIG-1:0] sb;
        sb = bus.seg_bus;
        dg = (m_t / SCAN_DIV) % NDIG;
        if (m_st == M_IDLE) begin
            e_seg = 7'h7F; e_an = '1;
        end else begin
            e_seg = sb[dg*7 +: 7]; e_an = '1; e_an[dg] = 1'b0;
        end
        m_t++;
        e_tick = 1'b0; e_done = 1'b0;
        if (sp) begin
            m_st = M_IDLE; m_frame = 0;
        end else if (s) begin
            m_mode   = (bus.mode == 2'b11) ? 0 : int'(bus.mode);
            m_period = FRAME_DIV << bus.speed;
            m_step   = bus.dir ? -1 : 1;
            m_frame  = bus.dir ? LAST : 0;
            m_el     = 0;
            m_st     = M_RUN;
        end else if (m_st == M_RUN) begin
            if (ps) m_st = M_PAUSE;
            else if (m_el == m_period - 1) begin m_el = 0; model_advance(); end
            else m_el++;
        end else if (m_st == M_PAUSE) begin
            if (!ps) m_st = M_RUN;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".frame"}, 64'(bus.frame), 64'(m_frame));
        chk({tag, ".seg"},   64'(bus.seg),   64'(e_seg));
        chk({tag, ".an"},    64'(bus.an),    64'(e_an));
        chk({tag, ".busy"},  64'(bus.busy),  64'(m_st == M_RUN || m_st == M_PAUSE));
        chk({tag, ".done"},  64'(bus.done),  64'(e_done));
        chk({tag, ".tick"},  64'(bus.frame_tick), 64'(e_tick));
    endtask

    task automatic cycle(input string tag, input logic s, input logic sp, input logic ps);
        logic [63:0] r;
        r = {$urandom, $urandom};
        bus.start = s; bus.stop = sp; bus.pause = ps;
        bus.seg_bus = r[7*NDIG-1:0];
        @(posedge clk);
        model_edge(s, sp, ps);
        #1;
        check_all(tag);
    endtask

    task automatic set_cfg(input logic [1:0] md, input logic d, input logic [1:0] sp);
        bus.mode = md; bus.dir = d; bus.speed = sp;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".frame"}, 64'(bus.frame), 64'(0));
        chk({tag, ".seg"},   64'(bus.seg),   64'(7'h7F));
        chk({tag, ".an"},    64'(bus.an),    64'({NDIG{1'b1}}));
        chk({tag, ".busy"},  64'(bus.busy),  64'(0));
        chk({tag, ".done"},  64'(bus.done),  64'(0));
        chk({tag, ".tick"},  64'(bus.frame_tick), 64'(0));
    endtask

    initial begin
        logic s, sp, ps;
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
        bus.seg_bus = '0;
        set_cfg(2'b00, 1'b0, 2'b00);
        model_reset();
        #22;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // loop, count up, base speed: full sweep and wrap
        set_cfg(2'b00, 1'b0, 2'b00);
        cycle("loop", 1'b1, 1'b0, 1'b0);
        repeat (32 * 4 + 8) cycle("loop", 1'b0, 1'b0, 1'b0);

        // one-shot, count down, speed 1: runs to 0 then done
        set_cfg(2'b01, 1'b1, 2'b01);
        cycle("oneshot", 1'b1, 1'b0, 1'b0);
        repeat (32 * 8 + 12) cycle("oneshot", 1'b0, 1'b0, 1'b0);
        cycle("restart_done", 1'b1, 1'b0, 1'b0);

        // one-shot up with start landing exactly on completion
        set_cfg(2'b01, 1'b0, 2'b00);
        cycle("os_race", 1'b1, 1'b0, 1'b0);
        repeat (32 * 4 - 1) cycle("os_race", 1'b0, 1'b0, 1'b0);
        cycle("os_race_start", 1'b1, 1'b0, 1'b0);
        repeat (6) cycle("os_race", 1'b0, 1'b0, 1'b0);

        // ping-pong: bounces at both endpoints
        set_cfg(2'b10, 1'b0, 2'b00);
        cycle("pingpong", 1'b1, 1'b0, 1'b0);
        repeat (70 * 4) cycle("pingpong", 1'b0, 1'b0, 1'b0);

        // pause with prescaler at 2, release, then stop during pause
        set_cfg(2'b00, 1'b0, 2'b00);
        cycle("pause", 1'b1, 1'b0, 1'b0);
        repeat (2) cycle("pause", 1'b0, 1'b0, 1'b0);
        repeat (10) cycle("pause_hold", 1'b0, 1'b0, 1'b1);
        repeat (5) cycle("pause_rel", 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("pause2", 1'b0, 1'b0, 1'b1);
        cycle("stop_pause", 1'b0, 1'b1, 1'b1);
        repeat (3) cycle("idle", 1'b0, 1'b0, 1'b0);

        // start and stop together: stop wins
        cycle("ss", 1'b1, 1'b0, 1'b0);
        repeat (3) cycle("ss", 1'b0, 1'b0, 1'b0);
        cycle("ss_both", 1'b1, 1'b1, 1'b0);
        repeat (3) cycle("ss", 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-run
        set_cfg(2'b10, 1'b1, 2'b00);
        cycle("arst", 1'b1, 1'b0, 1'b0);
        repeat (9) cycle("arst", 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst_now");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        ps = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            set_cfg(2'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
            s  = ($urandom_range(0, 39) == 0);
            sp = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) ps = ~ps;
            cycle("rand", s, sp, ps);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Frame sequencer and display scanner for the 7-segment LED animation path. Generates the 5-bit frame index that drives the per-digit pattern decoders, paces it with a programmable prescaler in loop, one-shot or ping-pong mode, and time-multiplexes the decoders' 7-bit active-low patterns onto one shared segment bus with active-low digit enables.

## Interface
- NDIG, 9: number of digits/decoders scanned.
- FRAME_DIV, 50000: base clk cycles per frame at speed 0.
- SCAN_DIV, 1000: clk cycles per digit scan slot.
- LAST, 31: final frame index; frame range is 0..LAST.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: (re)start animation.
- stop  in  1  pulse: abort to IDLE.
- pause  in  1  level: freeze while high.
- mode  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 treated as loop; latched at start.
- dir  in  1  0 count up, 1 count down; latched at start.
- speed  in  2  frame period = FRAME_DIV << speed; latched at start.
- seg_bus  in  7*NDIG  decoder outputs, digit k at [7k+6:7k], active-low.
- frame  out  5  current frame index to all decoders.
- seg  out  7  scanned segment pattern, active-low.
- an  out  NDIG  digit enables, active-low one-hot.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle pulse at one-shot completion.
- frame_tick  out  1  one-cycle pulse in the cycle frame changes.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: frame=0, display blanked (an all ones, seg 7'h7F); start -> RUN.
- On start: latch mode/dir/speed; frame loads 0 (dir=0) or LAST (dir=1); prescaler cleared; RUN.
- RUN: prescaler counts 0..(FRAME_DIV<<speed)-1; on terminal count frame steps ±1 and frame_tick pulses.
- Loop: LAST+1 wraps to 0, 0-1 wraps to LAST.
- Ping-pong: at endpoint reverse direction; endpoint shown once (…30,31,30…,1,0,1…).
- One-shot: tick at endpoint (LAST up, 0 down) -> DONE, frame holds endpoint, done pulses, no frame_tick.
- RUN with pause high -> PAUSE; prescaler and frame hold; pause low -> RUN, prescaler resumes from held value.
- DONE: display active showing final frame; start -> RUN.
- stop from any state -> IDLE, frame=0.
- Priority: stop > start > pause > tick. start in RUN/PAUSE restarts; a start coinciding with one-shot completion restarts and suppresses done. pause high in a terminal-count cycle suppresses the tick.
- Scanner: free-running slot counter 0..SCAN_DIV-1; on wrap digit index advances mod NDIG (8 -> 0). Runs in all states; only output blanking depends on state.
- Prescaler width: $clog2(FRAME_DIV*8); no overflow at speed 3.

## Timing
- Reset values: frame 0, seg 7'h7F, an all ones, busy 0, done 0, frame_tick 0, state IDLE, digit index 0, all counters 0.
- start sampled at edge N: busy and loaded frame visible after edge N.
- First frame step occurs FRAME_DIV<<speed cycles after start; period exact thereafter.
- frame_tick and done are registered, coincident with the frame/state change.
- seg/an registered: seg = seg_bus slice of current digit, one cycle latency; an[k]=0 for current digit k.
- Reset asserted mid-animation returns all outputs to reset values immediately (async).

## Structure
- Package anim_pkg: state enum, mode encodings (MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG), FRAME_W=5, SEG_BLANK=7'h7F.
- Sub-module led_scan: slot counter, digit index, seg/an registers, blank input; parameters NDIG, SCAN_DIV.
- Top holds FSM, prescaler, frame counter, direction flag.

## Test plan
- FRAME_DIV=4, speed=0, mode loop, dir 0, start: frame 0,1,…,31,0, frame_tick every 4 cycles, busy=1.
- One-shot dir 1 speed 1: frame 31 down to 0 every 8 cycles; one cycle after frame reaches 0 plus 8, done pulses once, busy=0, frame stays 0.
- Ping-pong LAST=3: sequence 0,1,2,3,2,1,0,1 with no repeated endpoint.
- Pause high 10 cycles mid-frame with prescaler at 2: frame/prescaler frozen; tick 2 cycles after release; stop during PAUSE -> IDLE, frame 0, an all ones.
- SCAN_DIV=2, seg_bus digit k = k: an walks 9'h1FE…9'h0FF every 2 cycles, seg matches slice one cycle later, wraps 8 -> 0.
- Assert rst_n low mid-RUN: all outputs at reset values same cycle; start and stop same cycle -> IDLE.
